// File: rtl/khu_sensor_pkg.sv
// Shared types and defaults for the KHU sensor I2C front end.
// Holds bus FSM encoding, event bundle and line-conditioner defaults.
package khu_sensor_pkg;

  localparam int I2C_SYNC_STAGES  = 2;
  localparam int I2C_FILT_LEN     = 4;
  localparam int I2C_IDLE_TIMEOUT = 1000;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic arb_lost;
  } i2c_evt_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Per-line synchronizer plus consecutive-sample glitch filter.
// line_nxt/line_upd expose the value the filter takes on the next edge.
module i2c_glitch_filter
  import khu_sensor_pkg::*;
#(
  parameter int SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int FILT_LEN    = I2C_FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_q,
  output logic line_nxt,
  output logic line_upd
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             cnt_q;
  logic                   synced;
  logic                   diff;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign diff     = synced ^ line_q;
  assign line_upd = diff && (cnt_q == CNT_LAST);
  assign line_nxt = line_upd ? synced : line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= 1'b1;
    end else begin
      line_q <= line_nxt;
      if (diff && !line_upd) begin
        cnt_q <= cnt_q + 4'd1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/mpr121_i2c_line_conditioner.sv
// Pad-side I2C line conditioner: filtering, bus events, busy tracking,
// arbitration-loss and clock-stretch detection for the MPR121 master.
module mpr121_i2c_line_conditioner
  import khu_sensor_pkg::*;
#(
  parameter int SYNC_STAGES  = I2C_SYNC_STAGES,
  parameter int FILT_LEN     = I2C_FILT_LEN,
  parameter int IDLE_TIMEOUT = I2C_IDLE_TIMEOUT
) (
  input  logic i_CLK,
  input  logic i_RSTN,
  input  logic i_SCL_IN,
  input  logic i_SDA_IN,
  input  logic i_SCL_DRIVE_LOW,
  input  logic i_SDA_DRIVE_LOW,
  input  logic i_ARB_EN,
  output logic o_SCL_OUT,
  output logic o_SDA_OUT,
  output logic o_SCL_EN,
  output logic o_SDA_EN,
  output logic o_SCL,
  output logic o_SDA,
  output logic o_SCL_RISE,
  output logic o_SCL_FALL,
  output logic o_START,
  output logic o_STOP,
  output logic o_ARB_LOST,
  output logic o_BUS_BUSY,
  output logic o_SCL_STRETCH
);

  localparam int         STRETCH_THR = SYNC_STAGES + FILT_LEN + 1;
  localparam logic [4:0] STRETCH_LIM = 5'(STRETCH_THR);
  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_TIMEOUT - 1);

  logic scl_f, scl_nxt, scl_upd;
  logic sda_f, sda_nxt, sda_upd;

  i2c_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_scl_filt (
    .clk     (i_CLK),
    .rst_n   (i_RSTN),
    .line_in (i_SCL_IN),
    .line_q  (scl_f),
    .line_nxt(scl_nxt),
    .line_upd(scl_upd)
  );

  i2c_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sda_filt (
    .clk     (i_CLK),
    .rst_n   (i_RSTN),
    .line_in (i_SDA_IN),
    .line_q  (sda_f),
    .line_nxt(sda_nxt),
    .line_upd(sda_upd)
  );

  logic       scl_en_q, sda_en_q;
  i2c_evt_t   evt_d, evt_q;
  bus_state_e state_q, state_d;
  logic [15:0] idle_cnt_q;
  logic        idle_hit;
  logic [4:0]  str_cnt_q, str_cnt_d;
  logic        str_q, str_d;

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      scl_en_q <= 1'b0;
      sda_en_q <= 1'b0;
    end else begin
      scl_en_q <= i_SCL_DRIVE_LOW;
      sda_en_q <= i_SDA_DRIVE_LOW;
    end
  end

  // Events are decoded from next-edge filter values so they line up
  // with the cycle in which the filtered level first changes.
  always_comb begin
    evt_d          = '0;
    evt_d.scl_rise = scl_upd && scl_nxt;
    evt_d.scl_fall = scl_upd && !scl_nxt;
    evt_d.start    = sda_upd && !sda_nxt && !scl_upd && scl_f;
    evt_d.stop     = sda_upd && sda_nxt && !scl_upd && scl_f;
    evt_d.arb_lost = evt_d.scl_rise && i_ARB_EN
                     && !sda_en_q && !sda_f;
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      idle_cnt_q <= '0;
    end else if (!(scl_f && sda_f)) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != 16'hffff) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  assign idle_hit = scl_f && sda_f && (idle_cnt_q == IDLE_LAST);

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUS_IDLE: begin
        if (evt_d.start || evt_d.scl_fall) state_d = BUS_BUSY;
      end
      BUS_BUSY: begin
        if (evt_q.stop || idle_hit) state_d = BUS_IDLE;
      end
    endcase
  end

  always_comb begin
    o_BUS_BUSY = (state_q == BUS_BUSY);
  end

  // Stretch flag uses next-edge SCL/enable so it drops together
  // with the filtered SCL rising or the core re-driving SCL.
  always_comb begin
    str_cnt_d = '0;
    if (!scl_en_q && !scl_f) begin
      str_cnt_d = (str_cnt_q == 5'h1f) ? str_cnt_q : str_cnt_q + 5'd1;
    end
    str_d = (str_cnt_d > STRETCH_LIM) && !scl_nxt && !i_SCL_DRIVE_LOW;
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      str_cnt_q <= '0;
      str_q     <= 1'b0;
    end else begin
      str_cnt_q <= str_cnt_d;
      str_q     <= str_d;
    end
  end

  assign o_SCL_OUT     = 1'b0;
  assign o_SDA_OUT     = 1'b0;
  assign o_SCL_EN      = scl_en_q;
  assign o_SDA_EN      = sda_en_q;
  assign o_SCL         = scl_f;
  assign o_SDA         = sda_f;
  assign o_SCL_RISE    = evt_q.scl_rise;
  assign o_SCL_FALL    = evt_q.scl_fall;
  assign o_START       = evt_q.start;
  assign o_STOP        = evt_q.stop;
  assign o_ARB_LOST    = evt_q.arb_lost;
  assign o_SCL_STRETCH = str_q;

endmodule
